// File: rtl/bcd_8421_pkg.sv
// Shared widths, limits and FSM encodings for the binary-to-BCD converter.
package bcd_8421_pkg;

    localparam int unsigned NUM_W     = 27;
    localparam int unsigned DIGITS    = 8;
    localparam int unsigned BCD_W     = 4 * DIGITS;
    localparam int unsigned SHIFT_CNT = 27;
    localparam int unsigned CNT_W     = $clog2(SHIFT_CNT);

    localparam logic [NUM_W-1:0] MAX_VAL   = NUM_W'(99_999_999);
    localparam logic [BCD_W-1:0] ALL_NINES = BCD_W'(32'h9999_9999);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

endpackage

// File: rtl/bcd_8421_add3.sv
// Double-dabble digit correction: add 3 to any nibble of 5 or more.
module bcd_add3 (
    input  logic [3:0] value,
    output logic [3:0] adjusted_c
);

    assign adjusted_c = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bcd_8421.sv
// Free-running sequential binary-to-8-digit-BCD converter; one shift per clock, 29-cycle period.
module bcd_8421
    import bcd_8421_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    output logic [3:0]       bit_0,
    output logic [3:0]       bit_1,
    output logic [3:0]       bit_2,
    output logic [3:0]       bit_3,
    output logic [3:0]       bit_4,
    output logic [3:0]       bit_5,
    output logic [3:0]       bit_6,
    output logic [3:0]       bit_7
);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [NUM_W-1:0] sr;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [BCD_W-1:0] digits;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .value      (acc[4*i +: 4]),
            .adjusted_c (acc_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:   state_next = ST_SHIFT;
            ST_SHIFT:  if (cnt == CNT_W'(SHIFT_CNT - 1)) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_LOAD;
            default:   state_next = ST_LOAD;
        endcase
    end

    // Out-of-range inputs are flagged at load since the 8-digit accumulator cannot hold them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            sat    <= 1'b0;
            digits <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    sr  <= num;
                    acc <= '0;
                    cnt <= '0;
                    sat <= (num > MAX_VAL);
                end
                ST_SHIFT: begin
                    acc <= {acc_adj[BCD_W-2:0], sr[NUM_W-1]};
                    sr  <= {sr[NUM_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                ST_UPDATE: begin
                    digits <= sat ? ALL_NINES : acc;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign bit_0 = digits[3:0];
    assign bit_1 = digits[7:4];
    assign bit_2 = digits[11:8];
    assign bit_3 = digits[15:12];
    assign bit_4 = digits[19:16];
    assign bit_5 = digits[23:20];
    assign bit_6 = digits[27:24];
    assign bit_7 = digits[31:28];

endmodule

// File: tb/tb_bcd_8421.sv
// Directed bench for bcd_8421 with a per-cycle arithmetic reference model.
module tb_bcd_8421;

    logic        clk;
    logic        rst;
    logic [26:0] num;
    logic [3:0]  bit_0, bit_1, bit_2, bit_3, bit_4, bit_5, bit_6, bit_7;
    logic [31:0] dut_bcd;

    int          checks;
    int          errors;
    int          edge_cnt;
    int unsigned sampled;
    logic [31:0] exp_val;
    logic [31:0] shown;

    bcd_8421 dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .bit_0 (bit_0),
        .bit_1 (bit_1),
        .bit_2 (bit_2),
        .bit_3 (bit_3),
        .bit_4 (bit_4),
        .bit_5 (bit_5),
        .bit_6 (bit_6),
        .bit_7 (bit_7)
    );

    assign dut_bcd = {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits by division, clamped to 99999999.
    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        x = (v > 99_999_999) ? 99_999_999 : v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: edge 1 after reset is a load, every 29th edge publishes that sample.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt = 0;
            exp_val  = '0;
        end else begin
            edge_cnt = edge_cnt + 1;
            if (edge_cnt % 29 == 1) sampled = int'(num);
            if (edge_cnt % 29 == 0) exp_val = to_bcd(sampled);
        end
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if (dut_bcd !== exp_val) begin
            errors = errors + 1;
            $display("FAIL model t=%0t got %h expected %h", $time, dut_bcd, exp_val);
        end
        checks = checks + 1;
        for (int i = 0; i < 8; i++) begin
            if (dut_bcd[4*i +: 4] > 4'd9) begin
                errors = errors + 1;
                $display("FAIL digit_range t=%0t digit %0d got %h expected <=9", $time, i, dut_bcd[4*i +: 4]);
                break;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Starts just before a load edge; checks hold at edge 28 and the new result at edge 29.
    task automatic run_conv(input logic [26:0] v, input logic [31:0] lit, input string name);
        num = v;
        repeat (28) @(posedge clk);
        #2;
        check({name, "_hold"}, dut_bcd, shown);
        @(posedge clk);
        #2;
        check(name, dut_bcd, lit);
        shown = lit;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        shown  = '0;
        num    = 27'd12345;
        rst    = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_zero", dut_bcd, 32'h0);
        rst = 1'b1;

        run_conv(27'd87_927_899, 32'h8792_7899, "conv_87927899");
        run_conv(27'd0,          32'h0000_0000, "conv_zero");
        run_conv(27'd99_999_999, 32'h9999_9999, "conv_max");
        run_conv(27'h7FF_FFFF,   32'h9999_9999, "sat_all_ones");
        run_conv(27'd100_000_000, 32'h9999_9999, "sat_boundary");
        run_conv(27'd12_345_678, 32'h1234_5678, "conv_12345678");

        // Input change mid-shift must not disturb the conversion in flight.
        num = 27'd5;
        repeat (10) @(posedge clk);
        #2 num = 27'd1234;
        repeat (18) @(posedge clk);
        #2;
        check("midshift_hold", dut_bcd, shown);
        @(posedge clk);
        #2;
        check("midshift_old", dut_bcd, 32'h0000_0005);
        shown = 32'h0000_0005;
        run_conv(27'd1234, 32'h0000_1234, "midshift_new");

        // Asynchronous abort mid-shift clears outputs without a clock edge.
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_clear", dut_bcd, 32'h0);
        shown = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run_conv(27'd4321, 32'h0000_4321, "after_abort");

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
